// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 slave byte engine.
// Synchronises CS_n and MOSI, deserialises MOSI MSB-first into bytes delivered
// over a valid/ready handshake, and serialises reply bytes onto MISO.
// Ports:
//   clk_ref, rst_n                   : system clock, synchronous active-low reset
//   sck_rise_pulse, sck_fall_pulse   : filtered SCK edge strobes
//   cs_n_raw, mosi_raw               : asynchronous SPI inputs
//   rx_data, rx_valid, rx_ready      : received byte handshake
//   tx_data, tx_req                  : reply byte source and request strobe
//   miso, miso_oe                    : serial output and its enable
//   frame_active/start/end, byte_idx : frame status
//   overflow, partial_err, clr_err   : sticky error flags and their clear
module spi_slave_rx_tx #(
    parameter int unsigned MOSI_DELAY = 3,
    parameter int unsigned CS_SYNC    = 2,
    parameter int unsigned IDX_W      = 16
) (
    input  logic             clk_ref,
    input  logic             rst_n,
    input  logic             sck_rise_pulse,
    input  logic             sck_fall_pulse,
    input  logic             cs_n_raw,
    input  logic             mosi_raw,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic [7:0]       tx_data,
    output logic             tx_req,
    output logic             miso,
    output logic             miso_oe,
    output logic             frame_active,
    output logic             frame_start,
    output logic             frame_end,
    output logic [IDX_W-1:0] byte_idx,
    output logic             overflow,
    output logic             partial_err,
    input  logic             clr_err
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CS_SYNC-1:0]    r_cs_sync;
    logic [MOSI_DELAY-1:0] r_mosi_sync;
    logic                  w_cs_s;
    logic                  w_mosi_s;

    logic [2:0]       r_bit_cnt;
    logic [6:0]       r_rx_sr;
    // Holds bits [6:0] of the byte being sent; bit 7 is already on MISO.
    logic [6:0]       r_tx_sr;
    logic [7:0]       r_tx_hold;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_tx_req;
    logic             r_miso;
    logic             r_frame_active;
    logic             r_frame_start;
    logic             r_frame_end;
    logic [IDX_W-1:0] r_byte_idx;
    logic             r_overflow;
    logic             r_partial_err;

    logic       w_start;
    logic       w_end;
    logic       w_rise;
    logic       w_fall;
    logic       w_byte_done;
    logic [7:0] w_rx_cand;
    logic       w_accept;
    logic       w_xfer;
    logic       w_ovf_set;
    logic       w_part_set;
    logic       w_tx_reload;
    logic       w_tx_shift;

    // CS_n synchroniser, idles deasserted.
    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            r_cs_sync <= '1;
        end else begin
            r_cs_sync <= {r_cs_sync[CS_SYNC-2:0], cs_n_raw};
        end
    end

    // MOSI synchroniser and delay line, aligned with SCK pulse latency.
    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[MOSI_DELAY-2:0], mosi_raw};
        end
    end

    assign w_cs_s   = r_cs_sync[CS_SYNC-1];
    assign w_mosi_s = r_mosi_sync[MOSI_DELAY-1];

    // State register.
    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. IDLE is only entered with cs_s high, so a low level
    // seen in IDLE is the falling edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (!w_cs_s) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (w_cs_s)  w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Event decode: CS deassertion beats SCK, rise beats a same-cycle fall.
    always_comb begin
        w_start = 1'b0;
        w_end   = 1'b0;
        w_rise  = 1'b0;
        w_fall  = 1'b0;
        case (r_state)
            ST_IDLE: w_start = !w_cs_s;
            ST_ACTIVE: begin
                if (w_cs_s) begin
                    w_end = 1'b1;
                end else if (sck_rise_pulse) begin
                    w_rise = 1'b1;
                end else if (sck_fall_pulse) begin
                    w_fall = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_byte_done = w_rise && (r_bit_cnt == 3'd7);
    assign w_rx_cand   = {r_rx_sr, w_mosi_s};
    assign w_xfer      = r_rx_valid && rx_ready;
    assign w_accept    = w_byte_done && (!r_rx_valid || rx_ready);
    assign w_ovf_set   = w_byte_done && r_rx_valid && !rx_ready;
    assign w_part_set  = w_end && (r_bit_cnt != 3'd0);
    // bit_cnt==0 with no completed byte means no rise yet: fall ignored.
    assign w_tx_reload = w_fall && (r_bit_cnt == 3'd0) && (r_byte_idx != '0);
    assign w_tx_shift  = w_fall && (r_bit_cnt != 3'd0);

    // Datapath and registered outputs.
    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            r_bit_cnt      <= 3'd0;
            r_rx_sr        <= 7'd0;
            r_tx_sr        <= 7'd0;
            r_tx_hold      <= 8'd0;
            r_rx_data      <= 8'd0;
            r_rx_valid     <= 1'b0;
            r_tx_req       <= 1'b0;
            r_miso         <= 1'b0;
            r_frame_active <= 1'b0;
            r_frame_start  <= 1'b0;
            r_frame_end    <= 1'b0;
            r_byte_idx     <= '0;
            r_overflow     <= 1'b0;
            r_partial_err  <= 1'b0;
        end else begin
            r_frame_start <= w_start;
            r_frame_end   <= w_end;
            r_tx_req      <= w_byte_done;

            if (r_tx_req) begin
                r_tx_hold <= tx_data;
            end

            if (w_start) begin
                r_frame_active <= 1'b1;
                r_bit_cnt      <= 3'd0;
                r_byte_idx     <= '0;
                r_tx_sr        <= tx_data[6:0];
                r_miso         <= tx_data[7];
            end else if (w_end) begin
                r_frame_active <= 1'b0;
                r_miso         <= 1'b0;
            end else if (w_rise) begin
                r_rx_sr   <= w_rx_cand[6:0];
                r_bit_cnt <= 3'(r_bit_cnt + 3'd1);
                if (w_byte_done && (r_byte_idx != '1)) begin
                    r_byte_idx <= IDX_W'(r_byte_idx + 1'b1);
                end
            end else if (w_tx_reload) begin
                r_tx_sr <= r_tx_hold[6:0];
                r_miso  <= r_tx_hold[7];
            end else if (w_tx_shift) begin
                r_tx_sr <= {r_tx_sr[5:0], 1'b0};
                r_miso  <= r_tx_sr[6];
            end

            if (w_accept) begin
                r_rx_data  <= w_rx_cand;
                r_rx_valid <= 1'b1;
            end else if (w_xfer) begin
                r_rx_valid <= 1'b0;
            end

            // Set wins over a same-cycle clear.
            r_overflow    <= w_ovf_set  | (r_overflow    & ~clr_err);
            r_partial_err <= w_part_set | (r_partial_err & ~clr_err);
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign tx_req       = r_tx_req;
    assign miso         = r_miso;
    assign miso_oe      = r_frame_active;
    assign frame_active = r_frame_active;
    assign frame_start  = r_frame_start;
    assign frame_end    = r_frame_end;
    assign byte_idx     = r_byte_idx;
    assign overflow     = r_overflow;
    assign partial_err  = r_partial_err;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Testbench for spi_slave_rx_tx: drives SPI frames at the pulse level and
// compares received bytes, MISO replies and status flags against expectations
// derived from byte lists.
module tb_spi_slave_rx_tx;

    localparam int unsigned IDX_W = 16;

    logic             clk_ref = 1'b0;
    logic             rst_n;
    logic             sck_rise_pulse;
    logic             sck_fall_pulse;
    logic             cs_n_raw;
    logic             mosi_raw;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [7:0]       tx_data;
    logic             tx_req;
    logic             miso;
    logic             miso_oe;
    logic             frame_active;
    logic             frame_start;
    logic             frame_end;
    logic [IDX_W-1:0] byte_idx;
    logic             overflow;
    logic             partial_err;
    logic             clr_err;

    int errors = 0;
    int checks = 0;
    int n_fs = 0;
    int n_fe = 0;
    int n_txreq = 0;
    logic [7:0] rx_got[$];
    logic lat_valid;
    logic lat_req;

    always #5 clk_ref = ~clk_ref;

    spi_slave_rx_tx #(
        .MOSI_DELAY(3),
        .CS_SYNC   (2),
        .IDX_W     (IDX_W)
    ) dut (
        .clk_ref       (clk_ref),
        .rst_n         (rst_n),
        .sck_rise_pulse(sck_rise_pulse),
        .sck_fall_pulse(sck_fall_pulse),
        .cs_n_raw      (cs_n_raw),
        .mosi_raw      (mosi_raw),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .tx_data       (tx_data),
        .tx_req        (tx_req),
        .miso          (miso),
        .miso_oe       (miso_oe),
        .frame_active  (frame_active),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .byte_idx      (byte_idx),
        .overflow      (overflow),
        .partial_err   (partial_err),
        .clr_err       (clr_err)
    );

    // Passive monitor: counts strobes and records every handshake transfer.
    always @(negedge clk_ref) begin
        if (frame_start) n_fs++;
        if (frame_end) n_fe++;
        if (tx_req) n_txreq++;
        if (rst_n && rx_valid && rx_ready) rx_got.push_back(rx_data);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_ref);
            #1;
        end
    endtask

    // One SCK period of 8 clocks; MISO is sampled when the rise is presented.
    task automatic send_bit(input logic b, input logic last, input logic [7:0] nxt,
                            input logic ready_on_rise, output logic m);
        mosi_raw = b;
        tick(3);
        m = miso;
        sck_rise_pulse = 1'b1;
        if (ready_on_rise) rx_ready = 1'b1;
        tick(1);
        sck_rise_pulse = 1'b0;
        if (last) begin
            lat_valid = rx_valid;
            lat_req   = tx_req;
            tx_data   = nxt;
        end
        tick(3);
        sck_fall_pulse = 1'b1;
        tick(1);
        sck_fall_pulse = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic [7:0] nxt,
                             input logic ready_on_last, output logic [7:0] m);
        logic mb;
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i], i == 0, nxt, ready_on_last && (i == 0), mb);
            m[i] = mb;
        end
    endtask

    task automatic start_frame(input logic [7:0] first);
        tx_data  = first;
        cs_n_raw = 1'b0;
        tick(6);
    endtask

    task automatic end_frame();
        cs_n_raw = 1'b1;
        tick(6);
    endtask

    task automatic run_frame(input int n, input logic [7:0] md[4], input logic [7:0] rp[5],
                             output logic [7:0] mo[4]);
        logic [7:0] mb;
        for (int k = 0; k < 4; k++) mo[k] = 8'h00;
        start_frame(rp[0]);
        for (int k = 0; k < n; k++) begin
            send_byte(md[k], rp[k+1], 1'b0, mb);
            mo[k] = mb;
        end
        end_frame();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(4);
        checks++;
        if ({rx_valid, rx_data, miso, miso_oe, frame_active} !== 12'h000) begin
            errors++;
            $display("FAIL reset_rx_miso: got %0h want 0", {rx_valid, rx_data, miso, miso_oe, frame_active});
        end
        checks++;
        if ({byte_idx, overflow, partial_err, tx_req, frame_start, frame_end} !== 21'h0) begin
            errors++;
            $display("FAIL reset_status: got %0h want 0", {byte_idx, overflow, partial_err, tx_req, frame_start, frame_end});
        end
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_single_byte();
        logic [7:0] mb;
        int base, fs0, fe0;
        rx_ready = 1'b1;
        base = rx_got.size();
        fs0 = n_fs;
        fe0 = n_fe;
        start_frame(8'hA5);
        checks++;
        if (frame_active !== 1'b1 || miso_oe !== 1'b1 || miso !== 1'b1) begin
            errors++;
            $display("FAIL single_start: active=%b oe=%b miso=%b want 1 1 1", frame_active, miso_oe, miso);
        end
        send_byte(8'h3C, 8'hA5, 1'b0, mb);
        checks++;
        if (lat_valid !== 1'b1 || lat_req !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: valid=%b req=%b want 1 1", lat_valid, lat_req);
        end
        end_frame();
        checks++;
        if (mb !== 8'hA5) begin
            errors++;
            $display("FAIL single_miso: got %h want a5", mb);
        end
        checks++;
        if (rx_got.size() != base + 1 || rx_got[rx_got.size()-1] !== 8'h3C) begin
            errors++;
            $display("FAIL single_rx: count=%0d last=%h want 1 3c", rx_got.size() - base,
                     rx_got.size() > 0 ? rx_got[rx_got.size()-1] : 8'hxx);
        end
        checks++;
        if (byte_idx !== 16'd1 || n_fs != fs0 + 1 || n_fe != fe0 + 1) begin
            errors++;
            $display("FAIL single_status: idx=%0d fs=%0d fe=%0d want 1 1 1", byte_idx, n_fs - fs0, n_fe - fe0);
        end
        checks++;
        if (miso_oe !== 1'b0 || frame_active !== 1'b0 || partial_err !== 1'b0) begin
            errors++;
            $display("FAIL single_end: oe=%b active=%b perr=%b want 0 0 0", miso_oe, frame_active, partial_err);
        end
    endtask

    task automatic test_multi_byte();
        logic [7:0] md[4];
        logic [7:0] rp[5];
        logic [7:0] mo[4];
        int base, tq0;
        md = '{8'h01, 8'h02, 8'h03, 8'h00};
        rp = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h00};
        rx_ready = 1'b1;
        base = rx_got.size();
        tq0 = n_txreq;
        run_frame(3, md, rp, mo);
        checks++;
        if (rx_got.size() != base + 3 || rx_got[base] !== 8'h01 || rx_got[base+1] !== 8'h02 || rx_got[base+2] !== 8'h03) begin
            errors++;
            $display("FAIL multi_rx: count=%0d want 3 bytes 01 02 03", rx_got.size() - base);
        end
        checks++;
        if (mo[0] !== 8'hA5 || mo[1] !== 8'h11 || mo[2] !== 8'h22) begin
            errors++;
            $display("FAIL multi_miso: got %h %h %h want a5 11 22", mo[0], mo[1], mo[2]);
        end
        checks++;
        if (byte_idx !== 16'd3 || n_txreq != tq0 + 3) begin
            errors++;
            $display("FAIL multi_idx: idx=%0d txreq=%0d want 3 3", byte_idx, n_txreq - tq0);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] md[4];
        logic [7:0] rp[5];
        logic [7:0] mo[4];
        int base, tq0, n;
        rx_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < 4; k++) md[k] = 8'($urandom);
            for (int k = 0; k < 5; k++) rp[k] = 8'($urandom);
            base = rx_got.size();
            tq0 = n_txreq;
            run_frame(n, md, rp, mo);
            checks++;
            if (rx_got.size() != base + n) begin
                errors++;
                $display("FAIL rand_rx_count f%0d: got %0d want %0d", f, rx_got.size() - base, n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    checks++;
                    if (rx_got[base+k] !== md[k]) begin
                        errors++;
                        $display("FAIL rand_rx f%0d b%0d: got %h want %h", f, k, rx_got[base+k], md[k]);
                    end
                end
            end
            for (int k = 0; k < n; k++) begin
                checks++;
                if (mo[k] !== rp[k]) begin
                    errors++;
                    $display("FAIL rand_miso f%0d b%0d: got %h want %h", f, k, mo[k], rp[k]);
                end
            end
            checks++;
            if (byte_idx !== 16'(n) || n_txreq != tq0 + n) begin
                errors++;
                $display("FAIL rand_idx f%0d: idx=%0d txreq=%0d want %0d", f, byte_idx, n_txreq - tq0, n);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] mb;
        int base;
        rx_ready = 1'b0;
        start_frame(8'h00);
        send_byte(8'h55, 8'h00, 1'b0, mb);
        send_byte(8'hAA, 8'h00, 1'b0, mb);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h55 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold: valid=%b data=%h ovf=%b want 1 55 1", rx_valid, rx_data, overflow);
        end
        end_frame();
        base = rx_got.size();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
        checks++;
        if (rx_got.size() != base + 1 || rx_got[rx_got.size()-1] !== 8'h55 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drain: count=%0d valid=%b want 1 0", rx_got.size() - base, rx_valid);
        end
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want 0", overflow);
        end
    endtask

    task automatic test_partial();
        logic mbit;
        logic [7:0] mb;
        int base, fe0;
        rx_ready = 1'b1;
        base = rx_got.size();
        start_frame(8'h00);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 8'h00, 1'b0, mbit);
        fe0 = n_fe;
        end_frame();
        checks++;
        if (rx_got.size() != base || partial_err !== 1'b1 || n_fe != fe0 + 1) begin
            errors++;
            $display("FAIL partial_flag: rx=%0d perr=%b fe=%0d want 0 1 1", rx_got.size() - base, partial_err, n_fe - fe0);
        end
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        start_frame(8'h00);
        send_byte(8'hF0, 8'h00, 1'b0, mb);
        end_frame();
        checks++;
        if (rx_got.size() != base + 1 || rx_got[rx_got.size()-1] !== 8'hF0 || partial_err !== 1'b0 || byte_idx !== 16'd1) begin
            errors++;
            $display("FAIL partial_next: count=%0d perr=%b idx=%0d want 1 0 1 (byte f0)",
                     rx_got.size() - base, partial_err, byte_idx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mb;
        logic [7:0] b1, b2;
        int base;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        rx_ready = 1'b0;
        base = rx_got.size();
        start_frame(8'h00);
        send_byte(b1, 8'h00, 1'b0, mb);
        send_byte(b2, 8'h00, 1'b1, mb);
        end_frame();
        checks++;
        if (rx_got.size() != base + 2 || rx_got[base] !== b1 || rx_got[base+1] !== b2) begin
            errors++;
            $display("FAIL simul_rx: count=%0d want 2 bytes %h %h", rx_got.size() - base, b1, b2);
        end
        checks++;
        if (overflow !== 1'b0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_flags: ovf=%b valid=%b want 0 0", overflow, rx_valid);
        end
    endtask

    task automatic test_reset_idle();
        logic mbit;
        int fe0, fs0, tq0;
        rx_ready = 1'b1;
        start_frame(8'hFF);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 8'h00, 1'b0, mbit);
        fe0 = n_fe;
        rst_n = 1'b0;
        tick(3);
        cs_n_raw = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(6);
        checks++;
        if (n_fe != fe0 || partial_err !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort: fe=%0d perr=%b ovf=%b want 0 0 0", n_fe - fe0, partial_err, overflow);
        end
        checks++;
        if ({rx_valid, rx_data, miso, miso_oe, frame_active, byte_idx} !== 28'h0) begin
            errors++;
            $display("FAIL rst_outputs: got %0h want 0", {rx_valid, rx_data, miso, miso_oe, frame_active, byte_idx});
        end
        fs0 = n_fs;
        tq0 = n_txreq;
        for (int i = 0; i < 16; i++) send_bit(1'($urandom), 1'b0, 8'h00, 1'b0, mbit);
        checks++;
        if (n_fs != fs0 || n_txreq != tq0 || rx_valid !== 1'b0 || byte_idx !== 16'd0 || miso !== 1'b0 || frame_active !== 1'b0) begin
            errors++;
            $display("FAIL idle_pulses: fs=%0d txreq=%0d valid=%b idx=%0d miso=%b active=%b want all 0",
                     n_fs - fs0, n_txreq - tq0, rx_valid, byte_idx, miso, frame_active);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        sck_rise_pulse = 1'b0;
        sck_fall_pulse = 1'b0;
        cs_n_raw       = 1'b1;
        mosi_raw       = 1'b0;
        rx_ready       = 1'b0;
        tx_data        = 8'h00;
        clr_err        = 1'b0;
        lat_valid      = 1'b0;
        lat_req        = 1'b0;
        test_reset();
        test_single_byte();
        test_multi_byte();
        test_random_frames();
        test_overflow();
        test_partial();
        test_back_to_back();
        test_reset_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx_tx.md
Name: spi_slave_rx_tx

Overview:
- SPI mode-0 slave byte engine. Sits directly downstream of the SCK synchroniser/glitch filter and consumes its `sck_rise_pulse` / `sck_fall_pulse`.
- Synchronises CS_n and MOSI, deserialises MOSI MSB-first into bytes, and hands them to the storage/command layer over valid/ready.
- Serialises reply bytes onto MISO. Reports frame boundaries and error flags.

Parameters:
- `MOSI_DELAY`, 3: synchroniser+delay stages on MOSI, so each sampled bit aligns with the SCK pulse latency (≥2).
- `CS_SYNC`, 2: synchroniser stages on CS_n (≥2).
- `IDX_W`, 16: width of the byte-in-frame counter.

Ports:
- `clk_ref`  in  1  system clock; everything is in this domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `sck_rise_pulse`  in  1  one-cycle pulse per accepted SCK rising edge.
- `sck_fall_pulse`  in  1  one-cycle pulse per accepted SCK falling edge.
- `cs_n_raw`  in  1  asynchronous chip select, active low.
- `mosi_raw`  in  1  asynchronous MOSI.
- `rx_data`  out  8  received byte.
- `rx_valid`  out  1  `rx_data` valid; held until `rx_ready`.
- `rx_ready`  in  1  consumer accepts `rx_data`.
- `tx_data`  in  8  next byte to send; sampled on the cycle `tx_req` is high, and at frame start.
- `tx_req`  out  1  one-cycle pulse: supply the next tx byte.
- `miso`  out  1  serial data out.
- `miso_oe`  out  1  MISO output enable (high while frame active).
- `frame_active`  out  1  high while synced CS_n is low.
- `frame_start`  out  1  one-cycle pulse on synced CS_n falling edge.
- `frame_end`  out  1  one-cycle pulse on synced CS_n rising edge.
- `byte_idx`  out  IDX_W  count of completed bytes in the current frame; saturates at all-ones.
- `overflow`  out  1  sticky: a completed byte was dropped.
- `partial_err`  out  1  sticky: a frame ended with 1–7 bits outstanding.
- `clr_err`  in  1  clears both sticky flags.

Behaviour:
- **Reset values:** all outputs 0 (`miso` 0, `miso_oe` 0, `rx_data` 0x00). Synchroniser chains reset to 1 for CS_n and 0 for MOSI. FSM goes to IDLE. Reset mid-frame aborts the frame silently: no `frame_end`, no error flags.
- **Synchronisation:** `cs_s` = CS_n after `CS_SYNC` flops; `mosi_s` = MOSI after `MOSI_DELAY` flops.
- **FSM state IDLE:**
  - Ignores SCK pulses.
  - On `cs_s` 1→0: go to ACTIVE, pulse `frame_start`, clear `bit_cnt` (3 bits) and `byte_idx`, load `tx_sr` ← `tx_data`, drive `miso` ← `tx_data[7]`.
- **FSM state ACTIVE:**
  - On `cs_s` 0→1: go to IDLE, pulse `frame_end`, drop `miso_oe`, discard partial bits. If `bit_cnt` ≠ 0, set `partial_err`.
  - CS_n deassertion has priority over any SCK pulse in the same cycle; that pulse is ignored.
- **Rise pulse (ACTIVE):**
  - `rx_sr` ← {`rx_sr[6:0]`, `mosi_s`}; `bit_cnt` increments, wrapping 7→0.
  - When `bit_cnt` was 7, the byte is complete: candidate = {`rx_sr[6:0]`, `mosi_s`}, `byte_idx` increments (saturating), and `tx_req` pulses on the next cycle.
- **Fall pulse (ACTIVE):**
  - If `bit_cnt` = 0 and at least one byte has completed: `tx_sr` ← `tx_data` as sampled at `tx_req`, and `miso` ← its bit 7.
  - Otherwise: `tx_sr` shifts left and `miso` ← new bit 7.
  - Fall pulses before the first rise of a frame are ignored.
- **Simultaneous SCK pulses:** if both pulses arrive in the same cycle (not expected from the filter), the rise pulse is processed and the fall pulse is dropped.
- **Tx data latch:** `tx_data` is captured into a holding register on the `tx_req` cycle. If the consumer does not update `tx_data`, the previous value is resent.
- **Output handshake:**
  - A transfer occurs when `rx_valid` && `rx_ready`; `rx_valid` then clears next cycle unless a new byte completes in the same cycle.
  - Byte completes with `rx_valid`=0, or with `rx_valid`&&`rx_ready`: `rx_data` ← candidate, `rx_valid` ← 1.
  - Byte completes with `rx_valid`=1 && !`rx_ready`: the new byte is dropped, the old byte is kept, and `overflow` is set.
- **Latency:** `rx_valid` rises 1 cycle after the 8th rise pulse.
- **Sticky flags:** `clr_err` clears `overflow` and `partial_err`. A set and a clear in the same cycle leaves the flag set.

Test Plan:
- **Single byte, MISO reply:** `tx_data`=0xA5 before CS low, 8 SCK periods of 8 `clk_ref` cycles, MOSI=0x3C → `rx_data`=0x3C with one `rx_valid`; MISO bits 1,0,1,0,0,1,0,1; `byte_idx`=1; one `frame_start` and one `frame_end`.
- **Multi-byte, backpressure-free:** MOSI 0x01,0x02,0x03, `rx_ready`=1; `tx_data` updated to 0x11,0x22 on each `tx_req` → 3 accepted bytes in order; MISO 0xA5,0x11,0x22; `byte_idx`=3.
- **Overflow:** `rx_ready`=0 across 2 bytes 0x55,0xAA → `rx_data` stays 0x55, `overflow`=1; raise `rx_ready`, pulse `clr_err` → `overflow`=0.
- **Partial frame:** CS deasserts after 5 bits → no `rx_valid`, `partial_err`=1, `frame_end` pulse; next frame with byte 0xF0 → received correctly with `bit_cnt` restarted.
- **Simultaneous handshake:** hold `rx_ready` low until the exact cycle the second byte completes → both bytes delivered, `overflow`=0.
- **Reset and idle pulses:** `rst_n` low mid-byte, then release with CS high → all outputs 0, no `frame_end`. SCK pulses while CS is high → no state change.
